mem_stage: RTL and testbench

Memory stage directly downstream of the execute stage; consumes the EXE/MEM pipeline register outputs (ALU_Res, Val_Rm, Dest, MEM_R_EN, MEM_W_EN, WB_EN).
- Performs word loads/stores to an external single-port SRAM with fixed wait states.
- Drives `ready` low while an access is in flight so the hazard/freeze logic stalls every upstream stage.
- Forwards results to the MEM/WB register.

---
 rtl/mem_pkg.sv | 18 +
 rtl/sram_ctrl.sv | 151 +++++++++++++++
 rtl/mem_stage.sv | 79 +++++++
 tb/tb_mem_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage.
//   state_e        : SRAM access FSM states (IDLE -> ACCESS -> DONE)
//   MEM_BASE_DEF   : default byte address that maps to SRAM word 0
//   SRAM_ADDR_W_DEF: default SRAM word-address width
//   WAIT_CNT_W     : wait-counter width, enough for SRAM_WAIT_CYCLES up to 15
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int MEM_BASE_DEF    = 1024;
  localparam int SRAM_ADDR_W_DEF = 17;
  localparam int WAIT_CNT_W      = 4;

endpackage

// File: rtl/sram_ctrl.sv
// SRAM access controller for the memory stage.
// Holds the access FSM, the wait-state counter, strobe generation, the
// registered address/write-data copies and the load-data capture register.
// Optional feature macro: MEM_STAGE_READ_BUF_EN adds a one-entry read buffer
// (valid, word address, data) that lets a repeated load complete in IDLE.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   rd_req_i       : load request
//   wr_req_i       : store request (wins when both requests are high)
//   addr_i         : translated SRAM word address
//   wdata_i        : store data
//   rdata_o        : registered load data (Mem_Data)
//   ready_o        : high when the pipeline may advance
//   sram_addr_o    : SRAM word address (registered copy)
//   sram_wdata_o   : SRAM write data (registered copy)
//   sram_rdata_i   : SRAM read data
//   sram_we_n_o    : active-low write strobe
//   sram_oe_n_o    : active-low output enable
module sram_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = SRAM_ADDR_W_DEF,
  parameter int WAIT_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ready_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i,
  output logic              sram_we_n_o,
  output logic              sram_oe_n_o
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  is_wr_q, is_wr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  buf_hit;
  logic [DATA_W-1:0]     buf_rdata;

  // The last wait cycle of a load is the only point where SRAM data is sampled.
  logic load_done;
  assign load_done = (state_q == ACCESS) && (cnt_q == LAST_CNT) && !is_wr_q;

`ifdef MEM_STAGE_READ_BUF_EN
  logic              buf_vld_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [DATA_W-1:0] buf_data_q;
  logic              buf_match;

  assign buf_match = buf_vld_q && (buf_addr_q == addr_i);
  // A pure load (store wins on dual request) hitting the entry bypasses SRAM.
  assign buf_hit   = (state_q == IDLE) && rd_req_i && !wr_req_i && buf_match;
  assign buf_rdata = buf_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld_q <= 1'b0;
    end else if (load_done) begin
      buf_vld_q  <= 1'b1;
      buf_addr_q <= addr_q;
      buf_data_q <= sram_rdata_i;
    end else if ((state_q == IDLE) && wr_req_i && buf_match) begin
      // Keep the entry coherent with a store accepted to the same word.
      buf_data_q <= wdata_i;
    end
  end
`else
  assign buf_hit   = 1'b0;
  assign buf_rdata = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (buf_hit) begin
          ready_o = 1'b1;
          rdata_d = buf_rdata;
        end else if (rd_req_i || wr_req_i) begin
          state_d = ACCESS;
          cnt_d   = '0;
          is_wr_d = wr_req_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end else begin
          ready_o = 1'b1;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          if (!is_wr_q) rdata_d = sram_rdata_i;
        end
      end
      DONE: begin
        // One-cycle ready pulse; requests still present are not re-accepted.
        ready_o = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o      = rdata_q;
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
  assign sram_we_n_o  = !((state_q == ACCESS) && is_wr_q);
  assign sram_oe_n_o  = !((state_q == ACCESS) && !is_wr_q);

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage between EXE/MEM and MEM/WB.
// Translates the byte address to an SRAM word address, passes the
// writeback controls through, and drives word loads/stores to an external
// single-port SRAM via sram_ctrl. ready low freezes the upstream pipeline.
// Optional feature macro: MEM_STAGE_READ_BUF_EN (one-entry read buffer).
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   MEM_R_EN, MEM_W_EN, WB_EN      : control from EXE/MEM
//   ALU_Res, Val_Rm, Dest          : address/result, store data, dest reg
//   WB_EN_out, MEM_R_EN_out,
//   ALU_Res_out, Dest_out          : combinational pass-throughs
//   Mem_Data                       : registered load data
//   ready                          : stage may advance
//   SRAM_ADDR, SRAM_WDATA,
//   SRAM_RDATA, SRAM_WE_N, SRAM_OE_N : SRAM interface
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDRESS_LEN      = 32,
  parameter int SRAM_ADDR_W      = SRAM_ADDR_W_DEF,
  parameter int MEM_BASE         = MEM_BASE_DEF,
  parameter int SRAM_WAIT_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic                   WB_EN,
  input  logic [ADDRESS_LEN-1:0] ALU_Res,
  input  logic [ADDRESS_LEN-1:0] Val_Rm,
  input  logic [3:0]             Dest,
  output logic                   WB_EN_out,
  output logic                   MEM_R_EN_out,
  output logic [ADDRESS_LEN-1:0] ALU_Res_out,
  output logic [3:0]             Dest_out,
  output logic [ADDRESS_LEN-1:0] Mem_Data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic [ADDRESS_LEN-1:0] SRAM_WDATA,
  input  logic [ADDRESS_LEN-1:0] SRAM_RDATA,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N
);

  // Modulo subtraction: addresses below MEM_BASE wrap silently.
  logic [ADDRESS_LEN-1:0] byte_off;
  logic [SRAM_ADDR_W-1:0] word_addr;
  logic                   unused_addr_bits;

  assign byte_off         = ALU_Res - ADDRESS_LEN'(MEM_BASE);
  assign word_addr        = byte_off[SRAM_ADDR_W+1:2];
  assign unused_addr_bits = ^{byte_off[1:0], byte_off[ADDRESS_LEN-1:SRAM_ADDR_W+2]};

  assign WB_EN_out    = WB_EN;
  assign MEM_R_EN_out = MEM_R_EN;
  assign ALU_Res_out  = ALU_Res;
  assign Dest_out     = Dest;

  sram_ctrl #(
    .DATA_W      (ADDRESS_LEN),
    .ADDR_W      (SRAM_ADDR_W),
    .WAIT_CYCLES (SRAM_WAIT_CYCLES)
  ) u_sram_ctrl (
    .clk          (clk),
    .rst          (rst),
    .rd_req_i     (MEM_R_EN),
    .wr_req_i     (MEM_W_EN),
    .addr_i       (word_addr),
    .wdata_i      (Val_Rm),
    .rdata_o      (Mem_Data),
    .ready_o      (ready),
    .sram_addr_o  (SRAM_ADDR),
    .sram_wdata_o (SRAM_WDATA),
    .sram_rdata_i (SRAM_RDATA),
    .sram_we_n_o  (SRAM_WE_N),
    .sram_oe_n_o  (SRAM_OE_N)
  );

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int W = 5;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN, WB_EN;
  logic [31:0] ALU_Res, Val_Rm;
  logic [3:0]  Dest;
  logic        WB_EN_out, MEM_R_EN_out;
  logic [31:0] ALU_Res_out;
  logic [3:0]  Dest_out;
  logic [31:0] Mem_Data;
  logic        ready;
  logic [16:0] SRAM_ADDR;
  logic [31:0] SRAM_WDATA, SRAM_RDATA;
  logic        SRAM_WE_N, SRAM_OE_N;

  int total = 0;
  int bad   = 0;

  logic [31:0] sram    [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] sb [$];

  mem_stage #(
    .ADDRESS_LEN      (32),
    .SRAM_ADDR_W      (17),
    .MEM_BASE         (1024),
    .SRAM_WAIT_CYCLES (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .WB_EN        (WB_EN),
    .ALU_Res      (ALU_Res),
    .Val_Rm       (Val_Rm),
    .Dest         (Dest),
    .WB_EN_out    (WB_EN_out),
    .MEM_R_EN_out (MEM_R_EN_out),
    .ALU_Res_out  (ALU_Res_out),
    .Dest_out     (Dest_out),
    .Mem_Data     (Mem_Data),
    .ready        (ready),
    .SRAM_ADDR    (SRAM_ADDR),
    .SRAM_WDATA   (SRAM_WDATA),
    .SRAM_RDATA   (SRAM_RDATA),
    .SRAM_WE_N    (SRAM_WE_N),
    .SRAM_OE_N    (SRAM_OE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: data only driven while output enable is asserted.
  assign SRAM_RDATA = !SRAM_OE_N ? sram[SRAM_ADDR[7:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR[7:0]] <= SRAM_WDATA;

  // Drives one request (called #1 after a rising edge), observes each cycle
  // at the falling edge until ready, then releases the request.
  task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, output int lat, output int we_c,
                            output int oe_c, output int lo_c,
                            output logic [16:0] addr_seen, output logic [31:0] md,
                            output logic [31:0] md_post);
    bit done;
    MEM_R_EN = r; MEM_W_EN = w; ALU_Res = a; Val_Rm = d;
    lat = 0; we_c = 0; oe_c = 0; lo_c = 0; addr_seen = '0; md = '0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (!SRAM_WE_N) we_c++;
      if (!SRAM_OE_N) oe_c++;
      if (!SRAM_WE_N || !SRAM_OE_N) addr_seen = SRAM_ADDR;
      if (ready) begin
        md = Mem_Data;
        done = 1;
      end else begin
        lo_c++;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL access_timeout: ready=%b after %0d cycles, required 1", ready, lat);
    end
    @(posedge clk); #1;
    md_post = Mem_Data;
    MEM_R_EN = 0; MEM_W_EN = 0;
  endtask

  task automatic test_reset;
    rst = 1; MEM_R_EN = 0; MEM_W_EN = 0; WB_EN = 0; ALU_Res = 0; Val_Rm = 0; Dest = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (SRAM_WE_N !== 1'b1) begin bad++; $display("FAIL reset_we_n: got %b want 1", SRAM_WE_N); end
    total++; if (SRAM_OE_N !== 1'b1) begin bad++; $display("FAIL reset_oe_n: got %b want 1", SRAM_OE_N); end
    total++; if (SRAM_ADDR !== 17'd0) begin bad++; $display("FAIL reset_addr: got %h want 0", SRAM_ADDR); end
    total++; if (SRAM_WDATA !== 32'd0) begin bad++; $display("FAIL reset_wdata: got %h want 0", SRAM_WDATA); end
    total++; if (Mem_Data !== 32'd0) begin bad++; $display("FAIL reset_mem_data: got %h want 0", Mem_Data); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready_idle: got %b want 1", ready); end
    MEM_R_EN = 1; #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready_req: got %b want 0", ready); end
    MEM_R_EN = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_nonmem;
    ALU_Res = 32'h55; WB_EN = 1; Dest = 4'hA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL nonmem_ready: got %b want 1", ready); end
      total++; if (ALU_Res_out !== 32'h55) begin bad++; $display("FAIL nonmem_alu_out: got %h want 55", ALU_Res_out); end
      total++; if ({SRAM_WE_N, SRAM_OE_N} !== 2'b11) begin bad++; $display("FAIL nonmem_strobes: got %b want 11", {SRAM_WE_N, SRAM_OE_N}); end
    end
    total++; if ({WB_EN_out, Dest_out, MEM_R_EN_out} !== {1'b1, 4'hA, 1'b0}) begin
      bad++; $display("FAIL nonmem_passthru: got %b/%h/%b want 1/a/0", WB_EN_out, Dest_out, MEM_R_EN_out);
    end
    WB_EN = 0; Dest = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_store;
    int lat, we_c, oe_c, lo_c; logic [16:0] as; logic [31:0] md, mp;
    ref_mem[1] = 32'hDEADBEEF;
    run_access(0, 1, 32'd1028, 32'hDEADBEEF, lat, we_c, oe_c, lo_c, as, md, mp);
    total++; if (lat !== W + 2) begin bad++; $display("FAIL store_latency: got %0d want %0d", lat, W + 2); end
    total++; if (we_c !== W) begin bad++; $display("FAIL store_we_cycles: got %0d want %0d", we_c, W); end
    total++; if (oe_c !== 0) begin bad++; $display("FAIL store_oe_cycles: got %0d want 0", oe_c); end
    total++; if (lo_c !== W + 1) begin bad++; $display("FAIL store_ready_low: got %0d want %0d", lo_c, W + 1); end
    total++; if (as !== 17'd1) begin bad++; $display("FAIL store_addr: got %h want 1", as); end
    total++; if (sram[1] !== ref_mem[1]) begin bad++; $display("FAIL store_sram_word: got %h want %h", sram[1], ref_mem[1]); end
  endtask

  task automatic test_load;
    int lat, we_c, oe_c, lo_c; logic [16:0] as; logic [31:0] md, mp, exp;
    sb.push_back(ref_mem[1]);
    run_access(1, 0, 32'd1028, 32'h0, lat, we_c, oe_c, lo_c, as, md, mp);
    total++; if (lat !== W + 2) begin bad++; $display("FAIL load_latency: got %0d want %0d", lat, W + 2); end
    total++; if (oe_c !== W || we_c !== 0) begin bad++; $display("FAIL load_strobes: oe=%0d we=%0d want %0d/0", oe_c, we_c, W); end
    exp = sb.pop_front();
    total++; if (md !== exp) begin bad++; $display("FAIL load_data: got %h want %h", md, exp); end
  endtask

  task automatic test_back_to_back;
    int lat, we_c, oe_c, lo_c; logic [16:0] as; logic [31:0] md, mp, exp, hold;
    sb.push_back(ref_mem[0]);
    run_access(1, 0, 32'd1024, 32'h0, lat, we_c, oe_c, lo_c, as, md, mp);
    exp = sb.pop_front();
    total++; if (md !== exp || lat !== W + 2) begin bad++; $display("FAIL b2b_first: data %h lat %0d want %h/%0d", md, lat, exp, W + 2); end
    total++; if (as !== 17'd0) begin bad++; $display("FAIL b2b_first_addr: got %h want 0", as); end
    sb.push_back(ref_mem[2]);
    run_access(1, 0, 32'd1032, 32'h0, lat, we_c, oe_c, lo_c, as, md, mp);
    exp = sb.pop_front();
    total++; if (md !== exp || lat !== W + 2) begin bad++; $display("FAIL b2b_second: data %h lat %0d want %h/%0d", md, lat, exp, W + 2); end
    total++; if (as !== 17'd2 || oe_c !== W) begin bad++; $display("FAIL b2b_second_addr: addr %h oe %0d want 2/%0d", as, oe_c, W); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (SRAM_OE_N !== 1'b1 || ready !== 1'b1) begin
        bad++; $display("FAIL b2b_no_retrigger: oe_n=%b ready=%b want 1/1", SRAM_OE_N, ready);
      end
    end
    // Dual request is a store; Mem_Data must keep the last loaded word.
    hold = exp;
    ref_mem[3] = 32'h5A5A_0003;
    @(posedge clk); #1;
    run_access(1, 1, 32'd1036, 32'h5A5A_0003, lat, we_c, oe_c, lo_c, as, md, mp);
    total++; if (we_c !== W || oe_c !== 0) begin bad++; $display("FAIL dual_is_store: we=%0d oe=%0d want %0d/0", we_c, oe_c, W); end
    total++; if (mp !== hold) begin bad++; $display("FAIL dual_mem_data: got %h want %h", mp, hold); end
    total++; if (sram[3] !== ref_mem[3]) begin bad++; $display("FAIL dual_sram_word: got %h want %h", sram[3], ref_mem[3]); end
  endtask

  task automatic test_reset_mid;
    MEM_R_EN = 1; ALU_Res = 32'd1028;
    repeat (4) @(negedge clk);
    total++; if (SRAM_OE_N !== 1'b0) begin bad++; $display("FAIL rstmid_inflight: oe_n=%b want 0", SRAM_OE_N); end
    rst = 1;
    @(negedge clk);
    total++; if ({SRAM_WE_N, SRAM_OE_N} !== 2'b11) begin bad++; $display("FAIL rstmid_strobes: got %b want 11", {SRAM_WE_N, SRAM_OE_N}); end
    total++; if (Mem_Data !== 32'd0) begin bad++; $display("FAIL rstmid_mem_data: got %h want 0", Mem_Data); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready: got %b want 0", ready); end
    MEM_R_EN = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    total++; if (ready !== 1'b1 || SRAM_OE_N !== 1'b1) begin bad++; $display("FAIL rstmid_idle: ready=%b oe_n=%b want 1/1", ready, SRAM_OE_N); end
    @(posedge clk); #1;
  endtask

`ifdef MEM_STAGE_READ_BUF_EN
  task automatic test_read_buf;
    int lat, we_c, oe_c, lo_c; logic [16:0] as; logic [31:0] md, mp, exp;
    sb.push_back(ref_mem[1]);
    run_access(1, 0, 32'd1028, 32'h0, lat, we_c, oe_c, lo_c, as, md, mp);
    exp = sb.pop_front();
    total++; if (md !== exp || lat !== W + 2) begin bad++; $display("FAIL rbuf_fill: data %h lat %0d want %h/%0d", md, lat, exp, W + 2); end
    sb.push_back(ref_mem[1]);
    run_access(1, 0, 32'd1028, 32'h0, lat, we_c, oe_c, lo_c, as, md, mp);
    exp = sb.pop_front();
    total++; if (lat !== 1 || oe_c !== 0) begin bad++; $display("FAIL rbuf_hit_timing: lat %0d oe %0d want 1/0", lat, oe_c); end
    total++; if (mp !== exp) begin bad++; $display("FAIL rbuf_hit_data: got %h want %h", mp, exp); end
    ref_mem[1] = 32'h0000_1234;
    run_access(0, 1, 32'd1028, 32'h0000_1234, lat, we_c, oe_c, lo_c, as, md, mp);
    total++; if (we_c !== W) begin bad++; $display("FAIL rbuf_store: we %0d want %0d", we_c, W); end
    sb.push_back(ref_mem[1]);
    run_access(1, 0, 32'd1028, 32'h0, lat, we_c, oe_c, lo_c, as, md, mp);
    exp = sb.pop_front();
    total++; if (lat !== 1 || oe_c !== 0) begin bad++; $display("FAIL rbuf_hit2_timing: lat %0d oe %0d want 1/0", lat, oe_c); end
    total++; if (mp !== exp) begin bad++; $display("FAIL rbuf_hit2_data: got %h want %h", mp, exp); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 32'hA000_0000 | 32'(i);
      ref_mem[i] = 32'hA000_0000 | 32'(i);
    end
    test_reset();
    test_nonmem();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_STAGE_READ_BUF_EN
    test_read_buf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
